if_id_stall_responder: RTL and testbench

//  Fetch-side responder to the stall/flush request interface: owns the PC register and the IF/ID

---
 rtl/if_id_stall_responder_pkg.sv | 22 ++
 rtl/if_id_stall_responder_if.sv | 35 +++
 rtl/if_id_stall_responder_sat_counter.sv | 33 +++
 rtl/if_id_stall_responder.sv | 108 ++++++++++
 tb/tb_if_id_stall_responder.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/if_id_stall_responder_pkg.sv
// Shared fetch-stage definitions: instruction width, bubble encoding and FSM state codes.
package if_id_stall_responder_pkg;

   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = '0;

   localparam logic [1:0] FETCH_RUN      = 2'd0;
   localparam logic [1:0] FETCH_HOLD     = 2'd1;
   localparam logic [1:0] FETCH_REDIRECT = 2'd2;

   typedef enum logic [1:0] {
      ST_RUN      = FETCH_RUN,
      ST_HOLD     = FETCH_HOLD,
      ST_REDIRECT = FETCH_REDIRECT
   } fetch_state_e;

   // Sequential fetch address; wraps modulo 2**32 with no carry out.
   function automatic logic [INSTR_W-1:0] next_word(input logic [INSTR_W-1:0] addr);
      return addr + INSTR_W'(4);
   endfunction

endpackage

// File: rtl/if_id_stall_responder_if.sv
// Stall/flush/redirect control plus IF/ID datapath bundle between the fetch responder and its driver.
interface if_id_stall_responder_if
   import if_id_stall_responder_pkg::*;
#(
   parameter int STALL_CNT_W = 8,
   parameter int PERF_W      = 32
);
   logic                   ID_Stall;
   logic                   Flush_IF_ID;
   logic                   Branch_Taken;
   logic [INSTR_W-1:0]     Branch_Target;
   logic [INSTR_W-1:0]     Instruction_In;
   logic [INSTR_W-1:0]     PC_Out;
   logic [INSTR_W-1:0]     IF_ID_Instruction;
   logic [INSTR_W-1:0]     IF_ID_PCPlus4;
   logic                   IF_ID_Valid;
   logic                   ID_EX_Bubble;
   logic [1:0]             Fetch_State;
   logic [STALL_CNT_W-1:0] Stall_Run_Count;
   logic [PERF_W-1:0]      Stall_Total;
   logic                   Stall_Timeout;

   modport master (
      output ID_Stall, Flush_IF_ID, Branch_Taken, Branch_Target, Instruction_In,
      input  PC_Out, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, ID_EX_Bubble,
             Fetch_State, Stall_Run_Count, Stall_Total, Stall_Timeout
   );

   modport slave (
      input  ID_Stall, Flush_IF_ID, Branch_Taken, Branch_Target, Instruction_In,
      output PC_Out, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, ID_EX_Bubble,
             Fetch_State, Stall_Run_Count, Stall_Total, Stall_Timeout
   );

endinterface

// File: rtl/if_id_stall_responder_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment, reset beats both.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] count_o
);
   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/if_id_stall_responder.sv
// Fetch-side responder: owns PC and IF/ID, obeys branch > stall > flush > advance on every edge,
// and tracks consecutive/total stall cycles with a sticky runaway-stall flag.
module if_id_stall_responder
   import if_id_stall_responder_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEFAULT,
   parameter int          STALL_CNT_W = 8,
   parameter int          MAX_STALL   = 16,
   parameter int          PERF_W      = 32
) (
   input logic                  Clk,
   input logic                  Reset,
   if_id_stall_responder_if.slave bus
);
   fetch_state_e       state_q, state_d;
   logic [INSTR_W-1:0] pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [INSTR_W-1:0] pc4_q, pc4_d;
   logic               valid_q, valid_d;
   logic               timeout_q, timeout_d;
   logic [INSTR_W-1:0] pc_plus4;
   logic               stall_eff;
   logic [STALL_CNT_W-1:0] run_count;
   logic [PERF_W-1:0]      total_count;

   assign pc_plus4  = next_word(pc_q);
   // A branch on the same edge overrides the stall, so it neither extends nor counts the run.
   assign stall_eff = bus.ID_Stall && !bus.Branch_Taken;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (bus.Branch_Taken) begin
         pc_d    = bus.Branch_Target;
         instr_d = NOP_INSTR;
         pc4_d   = '0;
         valid_d = 1'b0;
         state_d = ST_REDIRECT;
      end else if (bus.ID_Stall) begin
         // Flush is deliberately ignored here: the held instruction must survive the stall.
         state_d = ST_HOLD;
      end else if (bus.Flush_IF_ID) begin
         pc_d    = pc_plus4;
         instr_d = NOP_INSTR;
         pc4_d   = '0;
         valid_d = 1'b0;
         state_d = ST_RUN;
      end else begin
         pc_d    = pc_plus4;
         instr_d = bus.Instruction_In;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
         state_d = ST_RUN;
      end
   end

   assign timeout_d = timeout_q ||
                      (stall_eff && (run_count == STALL_CNT_W'(MAX_STALL - 1)));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= ST_RUN;
         pc_q      <= RESET_PC;
         instr_q   <= NOP_INSTR;
         pc4_q     <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         pc4_q     <= pc4_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   sat_counter #(.W(STALL_CNT_W)) u_run_cnt (
      .Clk     (Clk),
      .Reset   (Reset),
      .inc_i   (stall_eff),
      .clr_i   (!stall_eff),
      .count_o (run_count)
   );

   sat_counter #(.W(PERF_W)) u_total_cnt (
      .Clk     (Clk),
      .Reset   (Reset),
      .inc_i   (stall_eff),
      .clr_i   (1'b0),
      .count_o (total_count)
   );

   assign bus.PC_Out            = pc_q;
   assign bus.IF_ID_Instruction = instr_q;
   assign bus.IF_ID_PCPlus4     = pc4_q;
   assign bus.IF_ID_Valid       = valid_q;
   assign bus.ID_EX_Bubble      = bus.ID_Stall;
   assign bus.Fetch_State       = state_q;
   assign bus.Stall_Run_Count   = run_count;
   assign bus.Stall_Total       = total_count;
   assign bus.Stall_Timeout     = timeout_q;

endmodule

// File: tb/tb_if_id_stall_responder.sv
// Directed-vector bench for if_id_stall_responder with hand-computed expectations per step.
module tb_if_id_stall_responder;
   import if_id_stall_responder_pkg::*;

   logic Clk;
   logic Reset;
   int   n_vec  = 0;
   int   n_miss = 0;

   if_id_stall_responder_if #(.STALL_CNT_W(8), .PERF_W(32)) bus ();

   if_id_stall_responder #(
      .RESET_PC    (32'h0000_0000),
      .NOP_INSTR   (32'h0000_0000),
      .STALL_CNT_W (8),
      .MAX_STALL   (16),
      .PERF_W      (32)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic exp_all(input string tag, input logic [31:0] pc, input logic [31:0] ir,
                          input logic [31:0] pc4, input logic valid, input logic [1:0] st,
                          input int run, input int total, input logic to);
      chk({tag, ".pc"},    bus.PC_Out, pc);
      chk({tag, ".ir"},    bus.IF_ID_Instruction, ir);
      chk({tag, ".pc4"},   bus.IF_ID_PCPlus4, pc4);
      chk({tag, ".valid"}, 32'(bus.IF_ID_Valid), 32'(valid));
      chk({tag, ".state"}, 32'(bus.Fetch_State), 32'(st));
      chk({tag, ".run"},   32'(bus.Stall_Run_Count), 32'(run));
      chk({tag, ".total"}, bus.Stall_Total, 32'(total));
      chk({tag, ".tmo"},   32'(bus.Stall_Timeout), 32'(to));
   endtask

   // Apply one cycle of inputs, check the combinational bubble, then step past the edge.
   task automatic step(input logic st, input logic fl, input logic br,
                       input logic [31:0] tgt, input logic [31:0] ins);
      bus.ID_Stall       = st;
      bus.Flush_IF_ID    = fl;
      bus.Branch_Taken   = br;
      bus.Branch_Target  = tgt;
      bus.Instruction_In = ins;
      #1;
      chk("bubble", 32'(bus.ID_EX_Bubble), 32'(st));
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset              = 1'b1;
      bus.ID_Stall       = 1'b0;
      bus.Flush_IF_ID    = 1'b0;
      bus.Branch_Taken   = 1'b0;
      bus.Branch_Target  = '0;
      bus.Instruction_In = '0;
      repeat (2) @(posedge Clk);
      #1;
      exp_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, FETCH_RUN, 0, 0, 1'b0);
      Reset = 1'b0;

      // Three free cycles fetching A, B, C
      step(0, 0, 0, 32'h0, 32'hAAAA_0001);
      exp_all("adv1", 32'h4, 32'hAAAA_0001, 32'h4, 1'b1, FETCH_RUN, 0, 0, 1'b0);
      step(0, 0, 0, 32'h0, 32'hBBBB_0002);
      exp_all("adv2", 32'h8, 32'hBBBB_0002, 32'h8, 1'b1, FETCH_RUN, 0, 0, 1'b0);
      step(0, 0, 0, 32'h0, 32'hCCCC_0003);
      exp_all("adv3", 32'hC, 32'hCCCC_0003, 32'hC, 1'b1, FETCH_RUN, 0, 0, 1'b0);

      // Two-cycle stall holds PC and IF/ID
      step(1, 0, 0, 32'h0, 32'hDEAD_0000);
      exp_all("stall1", 32'hC, 32'hCCCC_0003, 32'hC, 1'b1, FETCH_HOLD, 1, 1, 1'b0);
      step(1, 0, 0, 32'h0, 32'hDEAD_0000);
      exp_all("stall2", 32'hC, 32'hCCCC_0003, 32'hC, 1'b1, FETCH_HOLD, 2, 2, 1'b0);

      // Branch overrides a concurrent stall
      step(1, 0, 1, 32'h100, 32'hDEAD_0000);
      exp_all("br_stall", 32'h100, 32'h0, 32'h0, 1'b0, FETCH_REDIRECT, 0, 2, 1'b0);
      step(0, 0, 0, 32'h0, 32'hDDDD_0004);
      exp_all("post_br", 32'h104, 32'hDDDD_0004, 32'h104, 1'b1, FETCH_RUN, 0, 2, 1'b0);

      // Redirect to 0x10, then flush alone
      step(0, 0, 1, 32'h10, 32'hDEAD_0000);
      exp_all("br10", 32'h10, 32'h0, 32'h0, 1'b0, FETCH_REDIRECT, 0, 2, 1'b0);
      step(0, 1, 0, 32'h0, 32'hDEAD_0001);
      exp_all("flush", 32'h14, 32'h0, 32'h0, 1'b0, FETCH_RUN, 0, 2, 1'b0);
      step(0, 0, 0, 32'h0, 32'hEEEE_0005);
      exp_all("adv_e", 32'h18, 32'hEEEE_0005, 32'h18, 1'b1, FETCH_RUN, 0, 2, 1'b0);

      // Flush with stall is ignored
      step(1, 1, 0, 32'h0, 32'hDEAD_0002);
      exp_all("fl_stall", 32'h18, 32'hEEEE_0005, 32'h18, 1'b1, FETCH_HOLD, 1, 3, 1'b0);
      step(0, 0, 0, 32'h0, 32'hFFFF_0006);
      exp_all("release", 32'h1C, 32'hFFFF_0006, 32'h1C, 1'b1, FETCH_RUN, 0, 3, 1'b0);

      // Runaway stall: timeout rises on the 16th edge
      for (int i = 1; i <= 16; i++) begin
         step(1, 0, 0, 32'h0, 32'hDEAD_0003);
         chk($sformatf("long%0d.run", i), 32'(bus.Stall_Run_Count), 32'(i));
         chk($sformatf("long%0d.tmo", i), 32'(bus.Stall_Timeout), (i >= 16) ? 32'd1 : 32'd0);
         chk($sformatf("long%0d.pc", i),  bus.PC_Out, 32'h1C);
      end
      chk("long.total", bus.Stall_Total, 32'd19);
      step(0, 0, 0, 32'h0, 32'h1111_0007);
      exp_all("tmo_rel1", 32'h20, 32'h1111_0007, 32'h20, 1'b1, FETCH_RUN, 0, 19, 1'b1);
      step(0, 0, 0, 32'h0, 32'h2222_0008);
      exp_all("tmo_rel2", 32'h24, 32'h2222_0008, 32'h24, 1'b1, FETCH_RUN, 0, 19, 1'b1);

      // PC wraparound
      step(0, 0, 1, 32'hFFFF_FFFC, 32'hDEAD_0004);
      exp_all("br_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, FETCH_REDIRECT, 0, 19, 1'b1);
      step(0, 0, 0, 32'h0, 32'h3333_0009);
      exp_all("wrap", 32'h0, 32'h3333_0009, 32'h0, 1'b1, FETCH_RUN, 0, 19, 1'b1);

      // Reset mid-stall
      step(1, 0, 0, 32'h0, 32'hDEAD_0005);
      exp_all("pre_rst", 32'h0, 32'h3333_0009, 32'h0, 1'b1, FETCH_HOLD, 1, 20, 1'b1);
      Reset = 1'b1;
      step(1, 0, 0, 32'h0, 32'hDEAD_0006);
      exp_all("rst_mid", 32'h0, 32'h0, 32'h0, 1'b0, FETCH_RUN, 0, 0, 1'b0);
      Reset = 1'b0;
      step(0, 0, 0, 32'h0, 32'h4444_000A);
      exp_all("post_rst", 32'h4, 32'h4444_000A, 32'h4, 1'b1, FETCH_RUN, 0, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
